// File: rtl/data_mem_responder.sv
// Load/store responder: one byte-addressed RISC-V sized access at a time on a word RAM,
// answered through a registered valid/ready response.
module data_mem_responder #(
    parameter int    DEPTH_WORDS = 2048,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mem [0:DEPTH_WORDS-1];
    logic [31:0] r_rd_word;
    logic [31:0] r_rsp_rdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_error;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic          w_hs;
    logic          w_f3_ok;
    logic          w_misal;
    logic          w_oob;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]    w_wdata;

    // Lane selection and sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign w_hs    = req_valid & r_req_ready;
    assign w_idx   = req_addr[2 +: AW];
    assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_oob   = (req_addr >> (AW + 2)) != 32'd0;
    assign w_err   = ~w_f3_ok | w_misal | w_oob;

    // Legal funct3 codes differ between loads and stores.
    always_comb begin
        w_f3_ok = 1'b0;
        if (req_write) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end
    end

    // Store data is replicated across lanes so byte enables alone pick the target bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = req_wdata;
            end
        endcase
    end

    // RAM port: byte-enabled store and synchronous load, both at the request handshake.
    always_ff @(posedge clk) begin
        if (w_hs && !w_err) begin
            if (req_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rd_word <= r_mem[w_idx];
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
            r_funct3    <= 3'd0;
            r_lane      <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_funct3    <= req_funct3;
                        r_lane      <= req_addr[1:0];
                        r_req_ready <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_error <= w_err;
                        if (w_err || req_write) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_rsp_rdata <= load_extend(r_rd_word, r_funct3, r_lane);
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array reference model, queue of expected
// responses, and an independent monitor checking data, error, latency and handshake rules.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mdl [0:NBYTES-1];
    logic [31:0] exp_d [$];
    bit          exp_e [$];
    int          exp_lat [$];
    int          hs_q [$];

    int          ncyc = 0;
    bit          active = 1'b0;
    bit          chk_next = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;
    int          rdy_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Consumer side: response ready policy (always, random, or held low).
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each new response and checks handshake behaviour.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            active   = 1'b0;
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk("ready_after_consume", {30'd0, req_ready, rsp_valid}, 32'd2);
                chk_next = 1'b0;
            end
            if (req_valid && req_ready) hs_q.push_back(ncyc);
            if (rsp_valid) begin
                if (!active) begin
                    if (exp_d.size() == 0 || hs_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        chk("rsp_rdata", rsp_rdata, exp_d.pop_front());
                        chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_e.pop_front()});
                        chk("latency", 32'(ncyc - hs_q.pop_front()), 32'(exp_lat.pop_front()));
                    end
                    active = 1'b1;
                    hold_d = rsp_rdata;
                    hold_e = rsp_error;
                end else begin
                    chk("rdata_stable", rsp_rdata, hold_d);
                    chk("error_stable", {31'd0, rsp_error}, {31'd0, hold_e});
                end
                chk("no_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (rsp_ready) begin
                    active   = 1'b0;
                    chk_next = 1'b1;
                end
            end
        end
    end

    // Reference model: applies a request to the byte array and returns the expected response.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output bit err);
        bit legal;
        int sz;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        err   = !legal || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00) || (a >= 32'(NBYTES));
        rd    = 32'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) mdl[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd[8*i +: 8] = mdl[int'(a) + i];
                if (!f3[2] && sz == 1) rd = {{24{rd[7]}}, rd[7:0]};
                if (!f3[2] && sz == 2) rd = {{16{rd[15]}}, rd[15:0]};
            end
        end
    endtask

    // Drive one request (entered at posedge+1), wait for its handshake, push the expectation.
    task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int hs_n);
        logic [31:0] rd;
        bit          err;
        int          n;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        hs_n = ncyc;
        if (n >= 200) begin
            chk("handshake_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            model(wr, f3, a, wd, rd, err);
            exp_d.push_back(rd);
            exp_e.push_back(err);
            exp_lat.push_back((wr || err) ? 1 : 2);
            #1;
            req_valid  = 1'b0;
            req_write  = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_d.size() != 0 || active) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    int hs;
    int prev_hs;
    bit prev_wr;
    logic [31:0] a;
    bit wr;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases from the basic access table.
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, hs);
        issue(1'b0, 3'b010, 32'h10, 32'h0, hs);
        issue(1'b1, 3'b000, 32'h11, 32'h00000055, hs);
        issue(1'b0, 3'b000, 32'h11, 32'h0, hs);
        issue(1'b0, 3'b100, 32'h13, 32'h0, hs);
        issue(1'b0, 3'b001, 32'h12, 32'h0, hs);
        issue(1'b0, 3'b101, 32'h12, 32'h0, hs);
        issue(1'b0, 3'b010, 32'h12, 32'h0, hs);
        issue(1'b0, 3'b001, 32'h13, 32'h0, hs);
        issue(1'b1, 3'b010, 32'(NBYTES), 32'hCAFEF00D, hs);
        issue(1'b0, 3'b011, 32'h10, 32'h0, hs);
        issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, hs);
        issue(1'b0, 3'b010, 32'h10, 32'h0, hs);

        // Fill a small region so random loads never see uninitialised words.
        for (int i = 0; i < 32; i++) issue(1'b1, 3'b010, 32'(i * 4), $urandom, hs);

        // Random traffic under random back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
            issue(1'($urandom_range(0, 1)), 3'($urandom), a, $urandom, hs);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        // Held response: ready low while a second request waits.
        rdy_mode = 2;
        issue(1'b0, 3'b010, 32'h10, 32'h0, hs);
        req_write = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h14;
        req_valid = 1'b1;
        repeat (6) @(posedge clk);
        rdy_mode = 0;
        issue(1'b0, 3'b010, 32'h14, 32'h0, hs);
        drain();

        // Back-to-back store/load pairs with the consumer always ready.
        prev_hs = -1;
        prev_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr = (i % 2 == 0);
            issue(wr, 3'b010, 32'h40, $urandom, hs);
            if (prev_hs >= 0) chk("b2b_spacing", 32'(hs - prev_hs), prev_wr ? 32'd2 : 32'd3);
            prev_hs = hs;
            prev_wr = wr;
        end
        drain();

        // Reset while a load is in READ; the earlier store must survive.
        issue(1'b1, 3'b010, 32'h20, 32'h12345678, hs);
        drain();
        req_write = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h20;
        req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
        hs_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h20, 32'h0, hs);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
